// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter and its memory: access widths,
// FSM states and the captured command record.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ALIGN_WORD = 2'b00,
    ALIGN_HALF = 2'b01,
    ALIGN_BYTE = 2'b10,
    ALIGN_RSVD = 2'b11
  } align_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    align_e      align;
    logic        sign;
    logic        err;
  } cmd_t;

  // Misaligned, reserved-width or out-of-range accesses are rejected at capture.
  function automatic logic access_err(input align_e align, input logic [31:0] addr,
                                      input logic [31:0] limit);
    logic e;
    e = (addr >= limit);
    case (align)
      ALIGN_WORD: e = e | (addr[1:0] != 2'b00);
      ALIGN_HALF: e = e | addr[0];
      ALIGN_BYTE: e = e;
      default:    e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: a lone requester wins, a tie goes
// to the requester that was not granted last.
module dm_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester data-memory arbiter: captures one command, drives the memory for
// a single ACCESS cycle, then returns a registered response to the owner.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] req_pc,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_we,
  input  logic [3:0]  req_align,
  input  logic [1:0]  req_sign,
  input  logic [63:0] req_wd,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic [31:0] dm_pc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [1:0]  dm_align,
  output logic        dm_sign,
  input  logic [31:0] dm_rd
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        last_gnt_q, last_gnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] pc_arr    [2];
  logic [31:0] addr_arr  [2];
  logic [31:0] wd_arr    [2];
  logic [1:0]  align_arr [2];

  logic pick_winner, pick_valid, capture;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign pc_arr[gi]    = req_pc[gi*32 +: 32];
      assign addr_arr[gi]  = req_addr[gi*32 +: 32];
      assign wd_arr[gi]    = req_wd[gi*32 +: 32];
      assign align_arr[gi] = req_align[gi*2 +: 2];
    end
  endgenerate

  dm_rr_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .winner   (pick_winner),
    .valid    (pick_valid)
  );

  assign capture = pick_valid && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: state_d = capture ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        state_d = ST_RESP;
      default:          state_d = ST_IDLE;
    endcase
  end

  // last_gnt only moves on capture, so it also names the owner of the access in flight.
  always_comb begin
    cmd_d      = cmd_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    if (capture) begin
      cmd_d.pc    = pc_arr[pick_winner];
      cmd_d.addr  = addr_arr[pick_winner];
      cmd_d.wd    = wd_arr[pick_winner];
      cmd_d.we    = req_we[pick_winner];
      cmd_d.align = align_e'(align_arr[pick_winner]);
      cmd_d.sign  = req_sign[pick_winner];
      cmd_d.err   = access_err(align_e'(align_arr[pick_winner]), addr_arr[pick_winner],
                               ADDR_LIMIT);
      last_gnt_d  = pick_winner;
      gnt_d[pick_winner] = 1'b1;
    end
    if (state_q == ST_ACCESS) begin
      rvalid_d[last_gnt_q] = 1'b1;
      err_d[last_gnt_q]    = cmd_q.err;
      rdata_d              = (cmd_q.we || cmd_q.err) ? 32'h0 : dm_rd;
    end
  end

  always_comb begin
    dm_we    = (state_q == ST_ACCESS) && cmd_q.we && !cmd_q.err;
    dm_pc    = cmd_q.pc;
    dm_addr  = cmd_q.addr;
    dm_wd    = cmd_q.wd;
    dm_align = cmd_q.align;
    dm_sign  = cmd_q.sign;
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: little-endian byte-lane memory model, directed requests,
// and a scoreboard monitor that checks grants and responses as they appear.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [63:0] req_pc = '0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_we = '0;
  logic [3:0]  req_align = '0;
  logic [1:0]  req_sign = '0;
  logic [63:0] req_wd = '0;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata, dm_pc, dm_addr, dm_wd, dm_rd;
  logic        dm_we, dm_sign;
  logic [1:0]  dm_align;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_pc(req_pc), .req_addr(req_addr),
    .req_we(req_we), .req_align(req_align), .req_sign(req_sign), .req_wd(req_wd),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we),
    .dm_align(dm_align), .dm_sign(dm_sign), .dm_rd(dm_rd)
  );

  // Memory model: preloaded with {A5A5, word index}, writes commit on posedge.
  logic [31:0] mem [4096];
  logic        mem_ready = 1'b0;
  logic [31:0] mem_word;
  logic [11:0] mem_idx;

  assign mem_idx  = dm_addr[13:2];
  assign mem_word = mem[mem_idx];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 4096; k++) mem[k] <= {16'hA5A5, 16'(k)};
      mem_ready <= 1'b1;
    end else if (dm_we) begin
      case (dm_align)
        2'b00: mem[mem_idx] <= dm_wd;
        2'b01: if (dm_addr[1]) mem[mem_idx][31:16] <= dm_wd[15:0];
               else            mem[mem_idx][15:0]  <= dm_wd[15:0];
        2'b10: mem[mem_idx][dm_addr[1:0]*8 +: 8] <= dm_wd[7:0];
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] lane_read(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] al, input logic s);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[a*8 +: 8];
    case (al)
      2'b01:   return s ? {{16{h[15]}}, h} : {16'h0, h};
      2'b10:   return s ? {{24{b[7]}}, b} : {24'h0, b};
      default: return w;
    endcase
  endfunction

  assign dm_rd = lane_read(mem_word, dm_addr[1:0], dm_align, dm_sign);

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  e;
    logic [31:0] d;
  } resp_t;

  resp_t      rq[$];
  logic [1:0] gq[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         we_cycles = 0;
  logic       forbid_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dm_we) we_cycles++;
        if (forbid_we) check("no_dm_we_on_error", 32'(dm_we), 32'd0);
        if (gnt != 2'b00) begin
          check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
          if (gq.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
          else                check("gnt_order", 32'(gnt), 32'(gq.pop_front()));
        end
        if (rvalid != 2'b00) begin
          $display("[TB] resp rvalid=%b err=%b rdata=%08h", rvalid, err, rdata);
          if (rq.size() == 0) check("rvalid_unexpected", 32'(rvalid), 32'd0);
          else begin
            e = rq.pop_front();
            check("rvalid", 32'(rvalid), 32'(e.v));
            check("err", 32'(err), 32'(e.e));
            check("rdata", rdata, e.d);
          end
        end else if (err != 2'b00) begin
          check("err_without_rvalid", 32'(err), 32'd0);
        end
      end
    end
  endtask

  task automatic set_fields(input int r, input logic we, input logic [31:0] addr,
                            input logic [1:0] align, input logic sign, input logic [31:0] wd);
    req_pc[r*32 +: 32]   = 32'h0000_8000 + addr;
    req_addr[r*32 +: 32] = addr;
    req_we[r]            = we;
    req_align[r*2 +: 2]  = align;
    req_sign[r]          = sign;
    req_wd[r*32 +: 32]   = wd;
  endtask

  task automatic push_resp(input int r, input logic e_err, input logic [31:0] e_rd);
    resp_t e;
    e.v = 2'(2'b01 << r);
    e.e = e_err ? 2'(2'b01 << r) : 2'b00;
    e.d = e_rd;
    rq.push_back(e);
  endtask

  // Raise one request, hold it until its grant shows, then drop it.
  task automatic issue(input int r, input logic we, input logic [31:0] addr,
                       input logic [1:0] align, input logic sign, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input logic e_resp);
    bit seen = 0;
    gq.push_back(2'(2'b01 << r));
    if (e_resp) push_resp(r, e_err, e_rd);
    set_fields(r, we, addr, align, sign, wd);
    req[r] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = gnt[r];
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
    req[r] = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = (rq.size() == 0) && (gq.size() == 0);
    end
    if (!done) check("drain_timeout", 32'(rq.size() + gq.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},    32'(gnt), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_err"},    32'(err), 32'd0);
    check({tag, "_dm_we"},  32'(dm_we), 32'd0);
  endtask

  initial begin
    int ngr;
    int last_k;
    int we_before;
    fork monitor(); join_none

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rdata", rdata, 32'd0);
    check("reset_dm_addr", dm_addr, 32'd0);
    check("reset_dm_wd", dm_wd, 32'd0);
    check("reset_dm_pc", dm_pc, 32'd0);
    check("reset_dm_align", 32'(dm_align), 32'd0);
    check("reset_dm_sign", 32'(dm_sign), 32'd0);
    rst = 1'b1;

    // Both requesters held: requester 0 wins the first tie, then strict alternation.
    set_fields(0, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0);
    set_fields(1, 1'b0, 32'h24, 2'b00, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      gq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      push_resp(i % 2, 1'b0, (i % 2 == 0) ? 32'hA5A5_0008 : 32'hA5A5_0009);
    end
    req = 2'b11;
    ngr = 0;
    last_k = 0;
    for (int k = 0; k < 40 && ngr < 4; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        ngr++;
        if (ngr > 1) check("gnt_spacing", 32'(k - last_k), 32'd2);
        last_k = k;
        if (ngr == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    check("tie_grant_count", 32'(ngr), 32'd4);
    drain();

    // Word write then read-back, exactly one dm_we cycle.
    we_before = we_cycles;
    issue(0, 1'b1, 32'h10, 2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    drain();
    check("write_dm_we_cycles", 32'(we_cycles - we_before), 32'd1);
    issue(0, 1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    drain();

    // Narrow reads with and without sign extension, back to back.
    issue(1, 1'b1, 32'h10, 2'b00, 1'b0, 32'h8001_0000, 1'b0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1);
    issue(1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 1'b0, 32'h0000_8001, 1'b1);
    issue(0, 1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0000_0080, 1'b1);
    issue(0, 1'b0, 32'h13, 2'b10, 1'b1, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
    issue(1, 1'b0, 32'h2FFC, 2'b00, 1'b0, 32'h0, 1'b0, 32'hA5A5_0BFF, 1'b1);
    drain();

    // Rejected accesses: never write, respond with err and zero data.
    forbid_we = 1'b1;
    issue(0, 1'b1, 32'h13,   2'b00, 1'b0, 32'h1111_1111, 1'b1, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h3000, 2'b00, 1'b0, 32'h2222_2222, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h11,   2'b01, 1'b0, 32'h0,         1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 32'h10,   2'b11, 1'b0, 32'h3333_3333, 1'b1, 32'h0, 1'b1);
    drain();
    forbid_we = 1'b0;
    issue(0, 1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0, 32'h8001_0000, 1'b1);
    drain();

    // Reset in the middle of a write access: no commit, no response.
    issue(0, 1'b1, 32'h40, 2'b00, 1'b0, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    #1;
    check("abort_dm_we_before", 32'(dm_we), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_dm_we_after", 32'(dm_we), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_dm_addr", dm_addr, 32'd0);
    repeat (2) @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b1;
    issue(0, 1'b0, 32'h40, 2'b00, 1'b0, 32'h0, 1'b0, 32'hA5A5_0010, 1'b1);
    drain();

    // Requests gone: everything settles idle.
    repeat (3) @(negedge clk);
    check_idle_outputs("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_3000, byte address bound; an access at or above it is an error.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req  in  2  per-requester request, bit i = requester i; held high until gnt[i].
REQ-005 req_pc  in  64  {pc1,pc0}, originating PC per requester, forwarded for trace.
REQ-006 req_addr  in  64  {addr1,addr0}, byte addresses.
REQ-007 req_we  in  2  write enable per requester.
REQ-008 req_align  in  4  {align1,align0}; 00 word, 01 half, 10 byte, 11 reserved.
REQ-009 req_sign  in  2  read sign-extend per requester.
REQ-010 req_wd  in  64  {wd1,wd0}, write data.
REQ-011 gnt  out  2  one-cycle pulse, request captured.
REQ-012 rvalid  out  2  one-cycle pulse, response for that requester.
REQ-013 rdata  out  32  read data, meaningful only with rvalid.
REQ-014 err  out  2  one-cycle pulse coincident with rvalid, access rejected.
REQ-015 dm_pc, dm_addr, dm_wd  out  32 each  memory-side command.
REQ-016 dm_we  out  1  memory write enable.
REQ-017 dm_align  out  2; dm_sign  out  1  memory width/sign controls.
REQ-018 dm_rd  in  32  memory combinational read data.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE after reset.
REQ-020 IDLE/RESP with any req bit high: winner captured into command registers, gnt[winner]=1 next cycle, state -> ACCESS.
REQ-021 IDLE/RESP with req==0: -> IDLE.
REQ-022 Arbitration round-robin: sole requester wins; both requesting -> requester other than last_gnt wins; last_gnt resets to 1 (requester 0 wins first tie).
REQ-023 last_gnt updates only on capture.
REQ-024 ACCESS lasts exactly one cycle; dm_* driven from command registers; dm_we = cmd_we & ~cmd_err.
REQ-025 Outside ACCESS: dm_we=0, other dm_* hold last command.
REQ-026 End of ACCESS: rdata <= dm_rd (zero on write or error), rvalid[owner]=1, err[owner]=cmd_err, state -> RESP.
REQ-027 cmd_err set at capture when: align==11; half with addr[0]=1; word with addr[1:0]!=0; addr >= ADDR_LIMIT.
REQ-028 Latency: req sampled at edge N -> gnt at N+1, memory write commits at edge N+2, rvalid/rdata at N+2 (visible cycle N+2..N+3); peak 1 access / 2 cycles.
REQ-029 Byte/half lane selection and sign extension are performed by memory; arbiter forwards align/sign unmodified.
REQ-030 req inputs may change after gnt without effect on the captured command.
REQ-031 gnt, rvalid, err are never asserted for both requesters in one cycle.

Reset
REQ-032 rst low: state=IDLE, gnt=0, rvalid=0, err=0, rdata=0, dm_we=0, dm_addr/dm_wd/dm_pc=0, dm_align=00, dm_sign=0, last_gnt=1, immediately (asynchronous).
REQ-033 Reset during ACCESS aborts the access; no write commits and no rvalid is issued.
REQ-034 First capture possible at first posedge after rst deasserts.

Structure
REQ-035 Shared package holds align encodings (word/half/byte/reserved) and FSM state encoding, reused by the memory and the arbiter.
REQ-036 One sub-module dm_rr_pick: combinational 2-way round-robin selector (req, last_gnt -> winner, valid).

Verification
REQ-037 req=01, addr0=0x10, we0=1, align0=00, wd0=0xDEADBEEF -> gnt=01 next cycle, dm_we=1 one cycle, rvalid=01 err=00; later read addr 0x10 returns 0xDEADBEEF.
REQ-038 Both req held continuously, reads -> grant order 0,1,0,1; no double grant; gnt pulses every 2 cycles.
REQ-039 Requester 1 half read signed at 0x12 after word 0x8001_0000 stored at 0x10 -> rdata=0xFFFF8001.
REQ-040 Requester 0 word write at 0x13, then addr 0x3000 -> each err=01 rvalid=01, dm_we never high, memory unchanged.
REQ-041 rst low during ACCESS of a write -> dm_we drops immediately, no rvalid, state IDLE, subsequent read shows old data.
REQ-042 req drops to 00 after gnt -> FSM returns to IDLE after RESP, all outputs idle.
